mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on the clk rising edge.
REQ-003 SHALL have ports i_valid/i_addr, input, 1/64, instruction-fetch request and byte address (read only).
REQ-004 SHALL have ports i_data_ok/i_data, output, 1/32, fetch completion pulse and instruction word.
REQ-005 SHALL have ports d_valid/d_addr/d_write/d_wdata/d_strobe, input, 1/64/1/64/8, data request, address, write flag, write data, byte strobe.
REQ-006 SHALL have ports d_data_ok/d_data, output, 1/64, data completion pulse and read data.
REQ-007 SHALL have ports m_valid/m_addr/m_write/m_wdata/m_strobe, output, 1/64/1/64/8, shared memory request.
REQ-008 SHALL have ports m_ok/m_rdata, input, 1/64, memory single-beat completion and read data.
REQ-009 SHALL have port m_owner, output, 1, current grant owner (0=I, 1=D), for debug only.

Function
REQ-010 SHALL implement FSM states IDLE and BUSY plus a 1-bit last-grant pointer lg (0=I, 1=D).
REQ-011 In IDLE, one requester valid SHALL grant it at the next edge; none valid SHALL stay IDLE.
REQ-012 In IDLE, both valid SHALL grant the port not equal to lg (round-robin), and lg SHALL be updated to the granted port.
REQ-013 On grant, the requester's addr/write/wdata/strobe SHALL be latched into registers; m_* SHALL be driven only from those registers.
REQ-014 m_valid SHALL be 1 for exactly the BUSY cycles and 0 in IDLE; m_* SHALL remain stable while m_valid=1 and m_ok=0.
REQ-015 I grants SHALL drive m_write=0 and m_strobe=0 and m_wdata=0.
REQ-016 In BUSY with m_ok=1, the FSM SHALL return to IDLE at that edge; the minimum gap between two grants is one IDLE cycle.
REQ-017 x_data_ok for the owner SHALL be combinational: asserted in the same cycle as m_ok, for one cycle only, and only if the owner's x_valid is still 1.
REQ-018 i_data SHALL be m_rdata[31:0] when m_addr[2]=0 and m_rdata[63:32] otherwise; d_data SHALL be m_rdata unmodified.
REQ-019 The non-owner's data_ok SHALL be 0 in every cycle, and both data_ok outputs SHALL be 0 in IDLE.
REQ-020 If the owner drops x_valid before m_ok (pipeline flush), the memory transaction SHALL still complete, and no data_ok SHALL be issued for it.
REQ-021 A request whose valid rises in the same cycle that m_ok completes another port's transaction SHALL be considered at the next IDLE cycle, not in that cycle.
REQ-022 A requester holding valid continuously across two back-to-back completions SHALL be treated as two separate requests.
REQ-023 i_data/d_data SHALL be don't-care when the matching data_ok=0; the bench SHALL not check them then.

Reset
REQ-024 While reset=1 at an edge, the FSM SHALL go to IDLE, lg=1, and the latched request registers SHALL be cleared to 0.
REQ-025 After reset, m_valid=0, m_owner=0, i_data_ok=0, and d_data_ok=0.
REQ-026 Reset asserted during BUSY SHALL abandon the transaction: m_valid=0 from the next cycle, with no data_ok; a late m_ok after reset SHALL be ignored.
REQ-027 Because lg=1 after reset, the first simultaneous I+D request SHALL be granted to I.

Verification
REQ-028 Release reset; i_valid=1, addr=0x8000_0004; m_ok=1 on the 3rd BUSY cycle, m_rdata=0x1111_2222_3333_4444 -> i_data_ok pulses 1 cycle, i_data=0x1111_2222.
REQ-029 i_valid=d_valid=1 held after reset, each with m_ok after 1 cycle -> grant order I, D, I, D; m_owner toggles; one IDLE cycle between grants.
REQ-030 D write addr=0x10, wdata=0xDEAD_BEEF, strobe=0x0F; m_ok delayed 5 cycles -> m_* stable for all 5 cycles, m_write=1; d_data_ok asserted only in the m_ok cycle.
REQ-031 I granted, i_valid dropped 1 cycle later, m_ok 2 cycles later -> no i_data_ok; FSM returns to IDLE; a pending d_valid is granted next.
REQ-032 Reset asserted in BUSY; m_ok=1 in the following cycle -> m_valid=0, no data_ok, state IDLE; next simultaneous request grants I.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-port memory arbiter: instruction-fetch port, data port
// and the shared single-beat memory port.
interface mem_arbiter_if;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_data_ok;
  logic [31:0] i_data;

  logic        d_valid;
  logic [63:0] d_addr;
  logic        d_write;
  logic [63:0] d_wdata;
  logic [7:0]  d_strobe;
  logic        d_data_ok;
  logic [63:0] d_data;

  logic        m_valid;
  logic [63:0] m_addr;
  logic        m_write;
  logic [63:0] m_wdata;
  logic [7:0]  m_strobe;
  logic        m_ok;
  logic [63:0] m_rdata;
  logic        m_owner;

  // Arbiter side: serves the requesters and masters the memory port.
  modport master (
    input  i_valid, i_addr,
    output i_data_ok, i_data,
    input  d_valid, d_addr, d_write, d_wdata, d_strobe,
    output d_data_ok, d_data,
    output m_valid, m_addr, m_write, m_wdata, m_strobe, m_owner,
    input  m_ok, m_rdata
  );

  // Environment side: requesters plus the memory model.
  modport slave (
    output i_valid, i_addr,
    input  i_data_ok, i_data,
    output d_valid, d_addr, d_write, d_wdata, d_strobe,
    input  d_data_ok, d_data,
    input  m_valid, m_addr, m_write, m_wdata, m_strobe, m_owner,
    output m_ok, m_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-beat memory port between an
// instruction-fetch requester and a data requester.
module mem_arbiter (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        lg_q, lg_d;
  logic        owner_q, owner_d;
  logic [63:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  strobe_q, strobe_d;
  logic        grant_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      lg_q     <= 1'b1;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      lg_q     <= lg_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strobe_q <= strobe_d;
    end
  end

  // Next-state and request capture; requests are only looked at in IDLE,
  // so a valid rising during a completing BUSY cycle waits for the next IDLE.
  always_comb begin
    state_d  = state_q;
    lg_d     = lg_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strobe_d = strobe_q;
    grant_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_valid || bus.d_valid) begin
          grant_d = (bus.i_valid && bus.d_valid) ? ~lg_q : bus.d_valid;
          state_d = BUSY;
          lg_d    = grant_d;
          owner_d = grant_d;
          if (grant_d) begin
            addr_d   = bus.d_addr;
            write_d  = bus.d_write;
            wdata_d  = bus.d_wdata;
            strobe_d = bus.d_strobe;
          end else begin
            addr_d   = bus.i_addr;
            write_d  = 1'b0;
            wdata_d  = '0;
            strobe_d = '0;
          end
        end
      end
      BUSY: begin
        if (bus.m_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; completion is forwarded only while the owner still wants it.
  always_comb begin
    bus.m_valid   = (state_q == BUSY);
    bus.m_addr    = addr_q;
    bus.m_write   = write_q;
    bus.m_wdata   = wdata_q;
    bus.m_strobe  = strobe_q;
    bus.m_owner   = owner_q;
    bus.i_data_ok = (state_q == BUSY) && !owner_q && bus.m_ok && bus.i_valid;
    bus.d_data_ok = (state_q == BUSY) &&  owner_q && bus.m_ok && bus.d_valid;
    bus.i_data    = addr_q[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
    bus.d_data    = bus.m_rdata;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mem_arbiter_if bif ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bif.i_valid = 0; bif.i_addr = '0;
    bif.d_valid = 0; bif.d_addr = '0; bif.d_write = 0; bif.d_wdata = '0; bif.d_strobe = '0;
    bif.m_ok = 0; bif.m_rdata = '0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_m_valid", {63'd0, bif.m_valid}, 64'd0);
    chk("rst_m_owner", {63'd0, bif.m_owner}, 64'd0);
    chk("rst_data_ok", {62'd0, bif.i_data_ok, bif.d_data_ok}, 64'd0);
    $display("txn reset: m_valid=%0d m_owner=%0d", bif.m_valid, bif.m_owner);

    // Single instruction fetch, completion on the third BUSY cycle
    bif.i_valid = 1; bif.i_addr = 64'h8000_0004;
    step();
    chk("if_m_valid", {63'd0, bif.m_valid}, 64'd1);
    chk("if_m_addr", bif.m_addr, 64'h8000_0004);
    chk("if_m_write", {63'd0, bif.m_write}, 64'd0);
    chk("if_m_strobe", {56'd0, bif.m_strobe}, 64'd0);
    chk("if_m_owner", {63'd0, bif.m_owner}, 64'd0);
    step();
    chk("if_wait_ok", {63'd0, bif.i_data_ok}, 64'd0);
    step();
    bif.m_ok = 1; bif.m_rdata = 64'h1111_2222_3333_4444;
    #1;
    chk("if_data_ok", {63'd0, bif.i_data_ok}, 64'd1);
    chk("if_data", {32'd0, bif.i_data}, 64'h1111_2222);
    chk("if_d_ok_zero", {63'd0, bif.d_data_ok}, 64'd0);
    $display("txn fetch: addr=%h i_data=%h", bif.m_addr, bif.i_data);
    step();
    bif.m_ok = 0; bif.i_valid = 0;
    #1;
    chk("if_idle_valid", {63'd0, bif.m_valid}, 64'd0);
    chk("if_idle_ok", {63'd0, bif.i_data_ok}, 64'd0);

    // Fresh reset, then both requesters held: I, D, I, D
    reset = 1; step(); reset = 0;
    bif.i_valid = 1; bif.i_addr = 64'h100;
    bif.d_valid = 1; bif.d_addr = 64'h20; bif.d_write = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_m_valid", {63'd0, bif.m_valid}, 64'd1);
      chk("rr_owner", {63'd0, bif.m_owner}, (k % 2 == 0) ? 64'd0 : 64'd1);
      chk("rr_addr", bif.m_addr, (k % 2 == 0) ? 64'h100 : 64'h20);
      step();
      bif.m_ok = 1; bif.m_rdata = 64'hA5A5_0000_0000_0000 + 64'(k);
      #1;
      chk("rr_i_ok", {63'd0, bif.i_data_ok}, (k % 2 == 0) ? 64'd1 : 64'd0);
      chk("rr_d_ok", {63'd0, bif.d_data_ok}, (k % 2 == 0) ? 64'd0 : 64'd1);
      if (k % 2 == 1) chk("rr_d_data", bif.d_data, 64'hA5A5_0000_0000_0000 + 64'(k));
      $display("txn rr %0d: owner=%0d i_ok=%0d d_ok=%0d", k, bif.m_owner, bif.i_data_ok, bif.d_data_ok);
      step();
      bif.m_ok = 0;
      if (k == 3) begin bif.i_valid = 0; bif.d_valid = 0; end
      #1;
      chk("rr_gap", {63'd0, bif.m_valid}, 64'd0);
      chk("rr_gap_ok", {62'd0, bif.i_data_ok, bif.d_data_ok}, 64'd0);
    end
    step();
    chk("rr_stay_idle", {63'd0, bif.m_valid}, 64'd0);

    // Data write with a 5-cycle stall; inputs change after grant
    bif.d_valid = 1; bif.d_write = 1; bif.d_addr = 64'h10;
    bif.d_wdata = 64'hDEAD_BEEF; bif.d_strobe = 8'h0F;
    step();
    bif.d_addr = 64'h999; bif.d_wdata = 64'h1234; bif.d_strobe = 8'hF0; bif.d_write = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("wr_stable", {bif.m_valid, bif.m_write, bif.m_strobe, bif.m_addr[53:0]},
          {1'b1, 1'b1, 8'h0F, 54'h10});
      chk("wr_wdata", bif.m_wdata, 64'hDEAD_BEEF);
      chk("wr_no_ok", {63'd0, bif.d_data_ok}, 64'd0);
      step();
    end
    bif.m_ok = 1; bif.m_rdata = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("wr_d_ok", {63'd0, bif.d_data_ok}, 64'd1);
    chk("wr_d_data", bif.d_data, 64'h0123_4567_89AB_CDEF);
    $display("txn write: addr=%h wdata=%h strobe=%h", bif.m_addr, bif.m_wdata, bif.m_strobe);
    // d_valid held across completion: a second, separate request follows
    step();
    bif.m_ok = 0;
    #1;
    chk("b2b_gap", {63'd0, bif.m_valid}, 64'd0);
    step();
    chk("b2b_regrant", {63'd0, bif.m_valid}, 64'd1);
    chk("b2b_addr", bif.m_addr, 64'h999);
    chk("b2b_write", {63'd0, bif.m_write}, 64'd0);
    bif.m_ok = 1; bif.d_valid = 0;
    #1;
    chk("b2b_flush_ok", {63'd0, bif.d_data_ok}, 64'd0);
    step();
    bif.m_ok = 0;
    #1;
    chk("b2b_idle", {63'd0, bif.m_valid}, 64'd0);

    // Flushed fetch, pending data request served next (lg=D so I wins)
    bif.i_valid = 1; bif.i_addr = 64'h200;
    bif.d_valid = 1; bif.d_addr = 64'h300; bif.d_write = 0;
    step();
    chk("fl_owner", {63'd0, bif.m_owner}, 64'd0);
    step();
    bif.i_valid = 0;
    step();
    bif.m_ok = 1;
    #1;
    chk("fl_no_ok", {62'd0, bif.i_data_ok, bif.d_data_ok}, 64'd0);
    $display("txn flush: owner=%0d i_ok=%0d", bif.m_owner, bif.i_data_ok);
    step();
    bif.m_ok = 0;
    #1;
    chk("fl_idle", {63'd0, bif.m_valid}, 64'd0);
    step();
    chk("fl_d_grant", {63'd0, bif.m_owner}, 64'd1);
    chk("fl_d_addr", bif.m_addr, 64'h300);
    bif.m_ok = 1; bif.m_rdata = 64'h55;
    #1;
    chk("fl_d_ok", {63'd0, bif.d_data_ok}, 64'd1);
    step();
    bif.m_ok = 0; bif.d_valid = 0;
    #1;

    // Lone I grant (lg=I), then reset while BUSY, late m_ok ignored
    bif.i_valid = 1; bif.i_addr = 64'h400;
    step();
    chk("rb_busy", {63'd0, bif.m_valid}, 64'd1);
    reset = 1;
    step();
    reset = 0; bif.m_ok = 1; bif.i_valid = 0;
    #1;
    chk("rb_m_valid", {63'd0, bif.m_valid}, 64'd0);
    chk("rb_no_ok", {62'd0, bif.i_data_ok, bif.d_data_ok}, 64'd0);
    chk("rb_m_addr", bif.m_addr, 64'd0);
    step();
    bif.m_ok = 0;
    #1;
    chk("rb_stay_idle", {63'd0, bif.m_valid}, 64'd0);
    bif.i_valid = 1; bif.i_addr = 64'h500;
    bif.d_valid = 1; bif.d_addr = 64'h600; bif.d_write = 1;
    bif.d_wdata = 64'hFFFF; bif.d_strobe = 8'hFF;
    step();
    chk("rb_first_i", {63'd0, bif.m_owner}, 64'd0);
    chk("rb_i_addr", bif.m_addr, 64'h500);
    chk("rb_i_wdata", {bif.m_wdata[62:0], bif.m_write}, 64'd0);
    $display("txn reset-busy: owner=%0d addr=%h", bif.m_owner, bif.m_addr);
    bif.m_ok = 1;
    step();
    bif.m_ok = 0; bif.i_valid = 0; bif.d_valid = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
